// File: rtl/edge_pipeline_param_if.sv
// Pixel-in / display-out bundle between the ZBT read path and the Sobel pipeline.
interface edge_pipeline_param_if;
  logic [23:0] rgb;
  logic [23:0] rgb1;
  logic [10:0] hcount;
  logic        in_valid;
  logic        sof;
  logic [1:0]  mode;
  logic [7:0]  thresh_in;
  logic        thresh_we;
  logic [23:0] edgeoutputsel;
  logic        select;
  logic        out_valid;

  modport master (
    output rgb, rgb1, hcount, in_valid, sof, mode, thresh_in, thresh_we,
    input  edgeoutputsel, select, out_valid
  );

  modport slave (
    input  rgb, rgb1, hcount, in_valid, sof, mode, thresh_in, thresh_we,
    output edgeoutputsel, select, out_valid
  );
endinterface

// File: rtl/edge_pipeline_param.sv
// Four-stage Sobel edge pipeline: gray -> line buffers/3x3 window -> gradients -> magnitude/mode.
module edge_pipeline_param #(
  parameter int unsigned COLS       = 1344,
  parameter int unsigned COL_W      = 11,
  parameter logic [7:0]  THRESH_DEF = 8'd64
) (
  input logic clock,
  input logic reset,
  edge_pipeline_param_if.slave bus
);

  localparam int unsigned PIX_W = 8;
  localparam int unsigned SUM_W = 10;
  localparam int unsigned GRD_W = 11;
  localparam int unsigned MAG_W = 12;

  // Input position tracking
  logic [COL_W-1:0] col_q, col_d, pos_col;
  logic [1:0]       row_q, row_d, pos_row;
  logic             wrap;

  // S1
  logic [23:0]      px;
  logic [15:0]      y_sum;
  logic             v1_q;
  logic [PIX_W-1:0] g1_q;
  logic [COL_W-1:0] col1_q;
  logic [1:0]       row1_q;

  // S2
  logic [PIX_W-1:0] lb0_mem [COLS];
  logic [PIX_W-1:0] lb1_mem [COLS];
  logic [PIX_W-1:0] win_q [3][3];
  logic             v2_q, mask2_q;

  // S3
  logic [SUM_W-1:0] sum_l, sum_r, sum_t, sum_b;
  logic [GRD_W-1:0] gx_d, gy_d, gx_q, gy_q;
  logic             v3_q, mask3_q;
  logic [PIX_W-1:0] cen3_q;

  // S4
  logic [GRD_W-1:0] abs_gx, abs_gy;
  logic [MAG_W-1:0] mag_sum;
  logic [PIX_W-1:0] mag, shade;
  logic             sel_d;
  logic [PIX_W-1:0] thr_q;
  logic [23:0]      pix_q;
  logic             sel_q, ov_q;

  logic             hcount_unused;
  assign hcount_unused = ^bus.hcount[10:1];

  // Pixel position for the incoming pixel; sof restarts at (0,0), row saturates at 2
  always_comb begin
    pos_col = bus.sof ? '0 : col_q;
    pos_row = bus.sof ? 2'd0 : row_q;
    wrap    = (pos_col == COL_W'(COLS - 1));
    col_d   = col_q;
    row_d   = row_q;
    if (bus.in_valid) begin
      col_d = wrap ? '0 : pos_col + COL_W'(1);
      row_d = (wrap && pos_row != 2'd2) ? pos_row + 2'd1 : pos_row;
    end
  end

  // Grayscale of the pixel selected by hcount[0]
  always_comb begin
    px    = bus.hcount[0] ? bus.rgb : bus.rgb1;
    y_sum = 16'(16'd77  * {8'd0, px[23:16]})
          + 16'(16'd150 * {8'd0, px[15:8]})
          + 16'(16'd29  * {8'd0, px[7:0]});
  end

  // Counters and S1 registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_q  <= '0;
      row_q  <= 2'd0;
      v1_q   <= 1'b0;
      g1_q   <= '0;
      col1_q <= '0;
      row1_q <= 2'd0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      v1_q  <= bus.in_valid;
      if (bus.in_valid) begin
        g1_q   <= y_sum[15:8];
        col1_q <= pos_col;
        row1_q <= pos_row;
      end
    end
  end

  // Line buffers: lb0 holds the previous line, lb1 the one before; contents are never cleared
  always_ff @(posedge clock) begin
    if (v1_q) begin
      lb0_mem[col1_q] <= g1_q;
      lb1_mem[col1_q] <= lb0_mem[col1_q];
    end
  end

  // S2: shift the 3x3 window left and load the new column (top = oldest line)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v2_q    <= 1'b0;
      mask2_q <= 1'b1;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= '0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= lb1_mem[col1_q];
        win_q[1][2] <= lb0_mem[col1_q];
        win_q[2][2] <= g1_q;
        mask2_q     <= (row1_q < 2'd2) || (col1_q < COL_W'(2));
      end
    end
  end

  // Weighted column/row sums; gradients kept as 11-bit two's complement
  always_comb begin
    sum_l = SUM_W'(win_q[0][0]) + SUM_W'({win_q[1][0], 1'b0}) + SUM_W'(win_q[2][0]);
    sum_r = SUM_W'(win_q[0][2]) + SUM_W'({win_q[1][2], 1'b0}) + SUM_W'(win_q[2][2]);
    sum_t = SUM_W'(win_q[0][0]) + SUM_W'({win_q[0][1], 1'b0}) + SUM_W'(win_q[0][2]);
    sum_b = SUM_W'(win_q[2][0]) + SUM_W'({win_q[2][1], 1'b0}) + SUM_W'(win_q[2][2]);
    gx_d  = GRD_W'(sum_r) - GRD_W'(sum_l);
    gy_d  = GRD_W'(sum_b) - GRD_W'(sum_t);
  end

  // S3 registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v3_q    <= 1'b0;
      mask3_q <= 1'b1;
      gx_q    <= '0;
      gy_q    <= '0;
      cen3_q  <= '0;
    end else begin
      v3_q    <= v2_q;
      mask3_q <= mask2_q;
      gx_q    <= gx_d;
      gy_q    <= gy_d;
      cen3_q  <= win_q[1][1];
    end
  end

  // Saturated magnitude with border masking, then display-mode shading
  always_comb begin
    abs_gx  = gx_q[GRD_W-1] ? (~gx_q + GRD_W'(1)) : gx_q;
    abs_gy  = gy_q[GRD_W-1] ? (~gy_q + GRD_W'(1)) : gy_q;
    mag_sum = MAG_W'(abs_gx) + MAG_W'(abs_gy);
    mag     = (mag_sum > MAG_W'(255)) ? 8'hFF : mag_sum[7:0];
    if (mask3_q) mag = '0;
    sel_d   = (mag > thr_q);
    shade   = mag;
    case (bus.mode)
      2'b00:   shade = ~mag;
      2'b01:   shade = cen3_q;
      2'b10:   shade = sel_d ? 8'hFF : 8'h00;
      default: shade = mag;
    endcase
  end

  // S4 registers and runtime threshold; outputs hold while no pixel is emitted
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      thr_q <= THRESH_DEF;
      ov_q  <= 1'b0;
      pix_q <= '0;
      sel_q <= 1'b0;
    end else begin
      if (bus.thresh_we) thr_q <= bus.thresh_in;
      ov_q <= v3_q;
      if (v3_q) begin
        pix_q <= {shade, shade, shade};
        sel_q <= sel_d;
      end
    end
  end

  assign bus.edgeoutputsel = pix_q;
  assign bus.select        = sel_q;
  assign bus.out_valid     = ov_q;

endmodule

// File: tb/tb_edge_pipeline_param.sv
// Scoreboard bench for edge_pipeline_param on a 16-column frame.
module tb_edge_pipeline_param;
  localparam int unsigned COLS  = 16;
  localparam int unsigned COL_W = 4;
  localparam int MAXR = 8;

  typedef struct {
    logic [23:0] pix;
    logic        sel;
    logic        pix_chk;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  edge_pipeline_param_if bus ();

  edge_pipeline_param #(.COLS(COLS), .COL_W(COL_W), .THRESH_DEF(8'd64)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  exp_t        q[$];
  int          checks = 0;
  int          failures = 0;
  logic [1:0]  md;
  int          thr;
  int          mr, mc;
  int          gimg [MAXR][COLS];
  logic [23:0] last_pix;
  logic        last_sel, last_known;
  logic [3:0]  hist;

  function automatic int gray_of(input logic [23:0] p);
    return (77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0])) >> 8;
  endfunction

  task automatic idle();
    @(posedge clock); #1;
  endtask

  task automatic set_mode(input logic [1:0] m);
    md = m;
    bus.mode = m;
  endtask

  // Drive one valid pixel and push the expected centre-pixel result
  task automatic drive_px(input logic [23:0] lo, input logic [23:0] hi,
                          input logic hsel, input logic sof_b);
    int g, gx, gy, mag, cen;
    logic s;
    logic [7:0] c8;
    exp_t e;
    if (sof_b) begin mr = 0; mc = 0; end
    g = gray_of(hsel ? lo : hi);
    if (mr < MAXR) gimg[mr][mc] = g;
    mag = 0;
    if (mr >= 2 && mc >= 2 && mr < MAXR) begin
      gx = (gimg[mr-2][mc] + 2 * gimg[mr-1][mc] + gimg[mr][mc])
         - (gimg[mr-2][mc-2] + 2 * gimg[mr-1][mc-2] + gimg[mr][mc-2]);
      gy = (gimg[mr][mc-2] + 2 * gimg[mr][mc-1] + gimg[mr][mc])
         - (gimg[mr-2][mc-2] + 2 * gimg[mr-2][mc-1] + gimg[mr-2][mc]);
      if (gx < 0) gx = -gx;
      if (gy < 0) gy = -gy;
      mag = gx + gy;
      if (mag > 255) mag = 255;
    end
    cen = (mr >= 1 && mc >= 1 && mr <= MAXR) ? gimg[mr-1][mc-1] : 0;
    s = (mag > thr);
    case (md)
      2'b00:   c8 = ~8'(mag);
      2'b01:   c8 = 8'(cen);
      2'b10:   c8 = s ? 8'hFF : 8'h00;
      default: c8 = 8'(mag);
    endcase
    e.pix = {c8, c8, c8};
    e.sel = s;
    e.pix_chk = (md != 2'b01) || (mr >= 1 && mc >= 1);
    q.push_back(e);
    bus.rgb = lo;
    bus.rgb1 = hi;
    bus.hcount = {10'(mc >> 1), hsel};
    bus.sof = sof_b;
    bus.in_valid = 1'b1;
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    bus.sof = 1'b0;
    if (mc == int'(COLS) - 1) begin mc = 0; mr++; end
    else mc++;
  endtask

  task automatic pixel_of(input int kind, input int r, input int c,
                          output logic [23:0] lo, output logic [23:0] hi, output logic hsel);
    logic [7:0] v;
    v = 8'd0;
    hsel = 1'b1;
    case (kind)
      0: v = 8'd100;
      1: v = (c < 10) ? 8'd0 : 8'd255;
      3: v = 8'(8 * c + ((r == 3 && c == 5) ? 1 : 0));
      default: v = 8'd0;
    endcase
    lo = {v, v, v};
    hi = {v, v, v};
    if (kind == 2) begin
      lo = 24'hFF0000;
      hi = 24'h0000FF;
      hsel = c[0];
    end
  endtask

  task automatic run_frame(input int kind, input int rows, input int max_gap);
    logic [23:0] lo, hi;
    logic hsel;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < int'(COLS); c++) begin
        pixel_of(kind, r, c, lo, hi, hsel);
        drive_px(lo, hi, hsel, (r == 0 && c == 0));
        if (max_gap > 0) repeat ($urandom_range(0, max_gap)) idle();
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin idle(); n++; end
    repeat (2) idle();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) idle();
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    checks++;
    if (bus.edgeoutputsel !== 24'h0) begin failures++; $display("FAIL reset_pixel got=%h want=000000", bus.edgeoutputsel); end
    checks++;
    if (bus.select !== 1'b0) begin failures++; $display("FAIL reset_select got=%b want=0", bus.select); end
    reset = 1'b0;
    repeat (2) idle();
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_idle got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_latency();
    int n;
    set_mode(2'b11);
    drive_px(24'h646464, 24'h646464, 1'b1, 1'b1);
    n = 1;
    while (bus.out_valid !== 1'b1 && n < 10) begin idle(); n++; end
    checks++;
    if (n != 4) begin failures++; $display("FAIL latency got=%0d want=4", n); end
    drain();
  endtask

  task automatic test_uniform();
    set_mode(2'b11);
    run_frame(0, 4, 0);
    drain();
    checks++;
    if (q.size() != 0) begin failures++; $display("FAIL uniform_drain left=%0d want=0", q.size()); end
  endtask

  task automatic test_step();
    set_mode(2'b11);
    run_frame(1, 4, 0);
    drain();
    set_mode(2'b00);
    run_frame(1, 4, 0);
    drain();
    checks++;
    if (q.size() != 0) begin failures++; $display("FAIL step_drain left=%0d want=0", q.size()); end
  endtask

  task automatic test_gray();
    set_mode(2'b01);
    run_frame(2, 4, 0);
    drain();
    checks++;
    if (q.size() != 0) begin failures++; $display("FAIL gray_drain left=%0d want=0", q.size()); end
  endtask

  // Ramp gives mag 64 (on the threshold) and 66 (just above) near the bump pixel
  task automatic test_threshold();
    set_mode(2'b10);
    run_frame(3, 5, 0);
    drain();
    bus.thresh_in = 8'd100;
    bus.thresh_we = 1'b1;
    idle();
    bus.thresh_we = 1'b0;
    thr = 100;
    run_frame(3, 5, 0);
    drain();
    checks++;
    if (q.size() != 0) begin failures++; $display("FAIL thresh_drain left=%0d want=0", q.size()); end
  endtask

  task automatic test_gaps();
    set_mode(2'b11);
    run_frame(1, 4, 2);
    drain();
    checks++;
    if (q.size() != 0) begin failures++; $display("FAIL gaps_drain left=%0d want=0", q.size()); end
  endtask

  task automatic test_reset_midline();
    logic [23:0] lo, hi;
    logic hsel;
    set_mode(2'b11);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < int'(COLS); c++)
        if (r < 2 || c < 12) begin
          pixel_of(1, r, c, lo, hi, hsel);
          drive_px(lo, hi, hsel, (r == 0 && c == 0));
        end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midreset_out_valid got=%b want=0", bus.out_valid); end
    checks++;
    if (bus.edgeoutputsel !== 24'h0) begin failures++; $display("FAIL midreset_pixel got=%h want=000000", bus.edgeoutputsel); end
    idle();
    reset = 1'b0;
    thr = 64;
    idle();
    run_frame(1, 4, 0);
    drain();
    checks++;
    if (q.size() != 0) begin failures++; $display("FAIL midreset_drain left=%0d want=0", q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rgb = '0; bus.rgb1 = '0; bus.hcount = '0; bus.in_valid = 1'b0; bus.sof = 1'b0;
    bus.mode = 2'b11; bus.thresh_in = '0; bus.thresh_we = 1'b0;
    reset = 1'b1; md = 2'b11; thr = 64; mr = 0; mc = 0;
    hist = '0; last_pix = '0; last_sel = 1'b0; last_known = 1'b1;

    // Scoreboard monitor: valid delay, popped results, and hold behaviour
    fork
      forever begin
        exp_t e;
        @(negedge clock);
        if (reset) begin
          hist = '0;
          q.delete();
          last_pix = '0;
          last_sel = 1'b0;
          last_known = 1'b1;
        end else begin
          checks++;
          if (bus.out_valid !== hist[3]) begin
            failures++;
            $display("FAIL out_valid_delay got=%b want=%b t=%0t", bus.out_valid, hist[3], $time);
          end
          if (bus.out_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
              failures++;
              $display("FAIL unexpected_output got=%h want=none t=%0t", bus.edgeoutputsel, $time);
            end else begin
              e = q.pop_front();
              if (e.pix_chk) begin
                checks++;
                if (bus.edgeoutputsel !== e.pix) begin
                  failures++;
                  $display("FAIL pixel got=%h want=%h t=%0t", bus.edgeoutputsel, e.pix, $time);
                end
              end
              if (bus.select !== e.sel) begin
                failures++;
                $display("FAIL select got=%b want=%b t=%0t", bus.select, e.sel, $time);
              end
              last_pix = e.pix;
              last_sel = e.sel;
              last_known = e.pix_chk;
            end
          end else if (last_known) begin
            checks++;
            if (bus.edgeoutputsel !== last_pix || bus.select !== last_sel) begin
              failures++;
              $display("FAIL hold got=%h/%b want=%h/%b t=%0t", bus.edgeoutputsel, bus.select, last_pix, last_sel, $time);
            end
          end
          hist = {hist[2:0], bus.in_valid};
        end
      end
    join_none

    test_reset();
    test_latency();
    test_uniform();
    test_step();
    test_gray();
    test_threshold();
    test_gaps();
    test_reset_midline();
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
